// File: rtl/hamming_encoder.sv
// Two-stage extended-Hamming (SECDED) encoder with valid/ready flow control on both sides.
// Optional error injection on the final codeword is enabled by defining HAMMING_ENCODER_ERR_INJECT_EN.
package gray_area_package;
  // Smallest r such that 2^r covers data bits, r parity bits and position 0.
  function automatic int hamming_address_width(input int data_width);
    int res;
    res = 0;
    for (int r = 1; r < 16; r++)
      if (res == 0 && (1 << r) >= data_width + r + 1) res = r;
    return res;
  endfunction
endpackage

module hamming_encoder #(
  parameter  int DATA_WIDTH = 26,
  localparam int ADDR_WIDTH = gray_area_package::hamming_address_width(DATA_WIDTH),
  localparam int CODE_WIDTH = DATA_WIDTH + ADDR_WIDTH + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
`ifdef HAMMING_ENCODER_ERR_INJECT_EN
  input  logic                          inj_en,
  input  logic [$clog2(CODE_WIDTH)-1:0] inj_pos,
`endif
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CODE_WIDTH-1:0]         out_code
);

  // Data positions covered by parity bit p_k (power-of-two positions excluded).
  function automatic logic [CODE_WIDTH-1:1] par_mask(input int k);
    logic [CODE_WIDTH-1:1] m;
    m = '0;
    for (int q = 3; q < CODE_WIDTH; q++)
      if (((q >> k) & 1) == 1 && (q & (q - 1)) != 0) m[q] = 1'b1;
    return m;
  endfunction

  logic [CODE_WIDTH-1:1] w_scat;
  logic [CODE_WIDTH-1:1] w_s1_d;
  logic [CODE_WIDTH-1:0] w_s2_code;
  logic                  w_s1_load;
  logic                  w_s2_load;

  logic                  r_s1_vld;
  logic [CODE_WIDTH-1:1] r_s1_code;
  logic                  r_s2_vld;
  logic [CODE_WIDTH-1:0] r_out_code;

  // Non-power-of-two position q carries data bit q - clog2(q) - 1.
  for (genvar q = 1; q < CODE_WIDTH; q++) begin : g_pos
    if ((q & (q - 1)) == 0) begin : g_par
      assign w_scat[q] = 1'b0;
      assign w_s1_d[q] = ^(w_scat & par_mask($clog2(q)));
    end else begin : g_dat
      assign w_scat[q] = in_data[q - $clog2(q) - 1];
      assign w_s1_d[q] = w_scat[q];
    end
  end

  assign w_s2_load = !r_s2_vld || out_ready;
  assign w_s1_load = !r_s1_vld || w_s2_load;
  assign in_ready  = w_s1_load;
  assign out_valid = r_s2_vld;
  assign out_code  = r_out_code;

`ifdef HAMMING_ENCODER_ERR_INJECT_EN
  logic                          r_s1_inj_en;
  logic [$clog2(CODE_WIDTH)-1:0] r_s1_inj_pos;
  logic [CODE_WIDTH-1:0]         w_inj_mask;

  always_ff @(posedge clk)
    if (w_s1_load && in_valid) begin
      r_s1_inj_en  <= inj_en;
      r_s1_inj_pos <= inj_pos;
    end

  // Positions beyond the codeword are silently ignored.
  assign w_inj_mask = (r_s1_inj_en && int'(r_s1_inj_pos) < CODE_WIDTH) ?
                      (CODE_WIDTH'(1) << r_s1_inj_pos) : '0;
  assign w_s2_code  = {r_s1_code, ^r_s1_code} ^ w_inj_mask;
`else
  assign w_s2_code  = {r_s1_code, ^r_s1_code};
`endif

  always_ff @(posedge clk)
    if (w_s1_load && in_valid) r_s1_code <= w_s1_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld   <= 1'b0;
      r_s2_vld   <= 1'b0;
      r_out_code <= '0;
    end else begin
      if (w_s1_load) r_s1_vld <= in_valid;
      if (w_s2_load) begin
        r_s2_vld <= r_s1_vld;
        if (r_s1_vld) r_out_code <= w_s2_code;
      end
    end
  end

endmodule

// File: tb/tb_hamming_encoder.sv
// Directed checks on a 4-bit encoder plus a randomized decode-based check on a 27-bit encoder.
module tb_hamming_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       iv, ir, ov, ordy;
  logic [3:0] id;
  logic [7:0] oc;

  logic        b_iv, b_ir, b_ov, b_ordy;
  logic [26:0] b_id;
  logic [33:0] b_oc;

`ifdef HAMMING_ENCODER_ERR_INJECT_EN
  logic       inj_en, b_inj_en;
  logic [2:0] inj_pos;
  logic [5:0] b_inj_pos;
`endif

  hamming_encoder #(.DATA_WIDTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .in_data(id),
`ifdef HAMMING_ENCODER_ERR_INJECT_EN
    .inj_en(inj_en), .inj_pos(inj_pos),
`endif
    .out_valid(ov), .out_ready(ordy), .out_code(oc)
  );

  hamming_encoder #(.DATA_WIDTH(27)) u_big (
    .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
`ifdef HAMMING_ENCODER_ERR_INJECT_EN
    .inj_en(b_inj_en), .inj_pos(b_inj_pos),
`endif
    .out_valid(b_ov), .out_ready(b_ordy), .out_code(b_oc)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Decoder-side view of a 34-bit word: data in ascending non-power-of-two positions.
  function automatic logic [26:0] extract(input logic [33:0] c);
    logic [26:0] d;
    int n;
    d = '0;
    n = 0;
    for (int q = 3; q < 34; q++)
      if ((q & (q - 1)) != 0) begin
        d[n] = c[q];
        n++;
      end
    return d;
  endfunction

  function automatic int syndrome(input logic [33:0] c);
    int s;
    s = 0;
    for (int q = 1; q < 34; q++)
      if (c[q]) s = s ^ q;
    return s;
  endfunction

  initial begin
    logic [26:0] q_exp[$];
    logic [26:0] e;
    int acc, sent, got, cyc;

    iv = 1'b0; id = '0; ordy = 1'b0;
    b_iv = 1'b0; b_id = '0; b_ordy = 1'b0;
`ifdef HAMMING_ENCODER_ERR_INJECT_EN
    inj_en = 1'b0; inj_pos = '0; b_inj_en = 1'b0; b_inj_pos = '0;
`endif

    #12;
    chk("rst_out_valid", 64'(ov), 64'd0);
    chk("rst_out_code", 64'(oc), 64'd0);
    chk("rst_in_ready", 64'(ir), 64'd1);
    chk("rst_big_valid", 64'(b_ov), 64'd0);
    step;
    rst_n = 1'b1;
    step;

    // Single beat latency.
    ordy = 1'b1; iv = 1'b1; id = 4'hB;
    chk("lat_in_ready", 64'(ir), 64'd1);
    step;
    iv = 1'b0;
    chk("lat_cycle1_valid", 64'(ov), 64'd0);
    step;
    chk("lat_cycle2_valid", 64'(ov), 64'd1);
    chk("lat_code_B", 64'(oc), 64'hAA);
    step;
    chk("lat_drained", 64'(ov), 64'd0);

    // Back-to-back beats.
    iv = 1'b1; id = 4'h0;
    step;
    chk("b2b_first_empty", 64'(ov), 64'd0);
    id = 4'hF;
    step;
    chk("b2b_valid0", 64'(ov), 64'd1);
    chk("b2b_code0", 64'(oc), 64'h00);
    id = 4'hB;
    step;
    iv = 1'b0;
    chk("b2b_codeF", 64'(oc), 64'hFF);
    step;
    chk("b2b_codeB", 64'(oc), 64'hAA);
    step;
    chk("b2b_drained", 64'(ov), 64'd0);

    // Stall: only two beats fit, output holds.
    ordy = 1'b0; iv = 1'b1; acc = 0;
    for (int i = 0; i < 5; i++) begin
      id = 4'(acc + 1);
      if (ir) acc++;
      step;
      if (i >= 1) begin
        chk("stall_valid", 64'(ov), 64'd1);
        chk("stall_code", 64'(oc), 64'h0F);
      end
    end
    chk("stall_accepted", 64'(acc), 64'd2);
    chk("stall_in_ready", 64'(ir), 64'd0);
    iv = 1'b0; ordy = 1'b1;
    step;
    chk("stall_drain_valid", 64'(ov), 64'd1);
    chk("stall_drain_code", 64'(oc), 64'h33);
    step;
    chk("stall_drain_empty", 64'(ov), 64'd0);

    // Reset with both stages full.
    ordy = 1'b0; iv = 1'b1; id = 4'hB;
    step;
    id = 4'hF;
    step;
    iv = 1'b0;
    chk("flush_pre_valid", 64'(ov), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("flush_async_valid", 64'(ov), 64'd0);
    chk("flush_async_code", 64'(oc), 64'd0);
    chk("flush_async_ready", 64'(ir), 64'd1);
    step;
    rst_n = 1'b1;
    ordy = 1'b1;
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      step;
      if (ov) acc++;
    end
    chk("flush_no_stale", 64'(acc), 64'd0);
    iv = 1'b1; id = 4'h1;
    step;
    iv = 1'b0;
    chk("flush_new_c1", 64'(ov), 64'd0);
    step;
    chk("flush_new_valid", 64'(ov), 64'd1);
    chk("flush_new_code", 64'(oc), 64'h0F);
    step;

`ifdef HAMMING_ENCODER_ERR_INJECT_EN
    iv = 1'b1; id = 4'hB; inj_en = 1'b1; inj_pos = 3'd0;
    step;
    inj_pos = 3'd7;
    step;
    iv = 1'b0; inj_en = 1'b0;
    chk("inj_pos0", 64'(oc), 64'hAB);
    step;
    chk("inj_pos7", 64'(oc), 64'h2A);
    step;
    b_ordy = 1'b1; b_iv = 1'b1; b_id = 27'h5A5A5A5; b_inj_en = 1'b1; b_inj_pos = 6'd40;
    step;
    b_iv = 1'b0; b_inj_en = 1'b0;
    step;
    chk("inj_out_of_range_synd", 64'(syndrome(b_oc)), 64'd0);
    chk("inj_out_of_range_par", 64'(^b_oc), 64'd0);
    step;
`endif

    // Randomized traffic on the 27-bit encoder, checked by decoding.
    sent = 0; got = 0; cyc = 0;
    while (got < 3000 && cyc < 20000) begin
      b_iv   = (sent < 3000) && ($urandom_range(0, 9) < 7);
      b_id   = 27'($urandom);
      b_ordy = $urandom_range(0, 9) < 6;
      #1;
      if (b_iv && b_ir) begin
        q_exp.push_back(b_id);
        sent++;
      end
      if (b_ov && b_ordy) begin
        if (q_exp.size() == 0) begin
          chk("rand_extra_beat", 64'd1, 64'd0);
        end else begin
          e = q_exp.pop_front();
          chk("rand_data", 64'(extract(b_oc)), 64'(e));
          chk("rand_syndrome", 64'(syndrome(b_oc)), 64'd0);
          chk("rand_parity", 64'(^b_oc), 64'd0);
        end
        got++;
      end
      step;
      cyc++;
    end
    b_iv = 1'b0;
    chk("rand_beats", 64'(got), 64'd3000);
    chk("rand_leftover", 64'(q_exp.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
    $finish;
  end
endmodule
